// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types, defaults and width helpers
// Purpose: common definitions for the hazard scoreboard and its comparator.
// Contents: NOP encoding, tag_entry_t stage record, default NREG/DEPTH,
//           tag/select width helpers.
package pipe_pkg;

    localparam logic [15:0] NOP       = 16'h0800;
    localparam int          DEF_NREG  = 8;
    localparam int          DEF_DEPTH = 3;

    // Stage records carry a fixed-width tag so the struct is NREG-independent;
    // narrower register tags are zero-extended into it.
    localparam int          TAG_MAX   = 8;

    typedef struct packed {
        logic               v;
        logic               wr;
        logic               ld;
        logic [TAG_MAX-1:0] ws;
    } tag_entry_t;

    function automatic int tag_w(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - compare one source tag against every in-flight stage
// Purpose: combinational RAW detector for a single decode-stage source.
// Ports: valid/used/src   - decode-stage source request
//        entries          - stage records, index 0 = EX (youngest)
//        match            - per-stage hit vector
//        sel              - 1 + index of youngest hit, 0 when none
//        any              - at least one hit
//        load_use         - youngest hit is a load sitting in EX
module sb_match
    import pipe_pkg::*;
#(
    parameter  int NREG  = DEF_NREG,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int RW    = tag_w(NREG),
    localparam int SW    = sel_w(DEPTH)
) (
    input  logic                   valid,
    input  logic                   used,
    input  logic [RW-1:0]          src,
    input  tag_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]       match,
    output logic [SW-1:0]          sel,
    output logic                   any,
    output logic                   load_use
);

    logic [TAG_MAX-1:0] src_ext;
    logic               youngest_ld;

    assign src_ext = TAG_MAX'(src);

    // Walk oldest to youngest so the last hit written is the youngest one.
    always_comb begin
        match       = '0;
        sel         = '0;
        youngest_ld = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid && used && entries[i].v && entries[i].wr &&
                (entries[i].ws == src_ext)) begin
                match[i]    = 1'b1;
                sel         = SW'(i + 1);
                youngest_ld = entries[i].ld;
            end
        end
    end

    assign any      = |match;
    assign load_use = match[0] & youngest_ld;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard scoreboard beside the decode stage
// Purpose: tracks in-flight register writes in a DEPTH-entry tag pipeline
//          (EX..WB), raises stall on RAW hazards, selects bypass sources.
// Build option: define HAZARD_SB_FWD_EN to enable forwarding (stall only on
//          load-use); otherwise any pending-write match stalls.
// Ports: clk, rst (async, active high)
//        id_valid, id_rs1/2, id_rs1/2_used, id_ws, id_wr, id_ld, flush
//        stall, fwd_sel1/2 (0 = RF, k = stage k-1), busy_vec, stall_count
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter  int NREG  = DEF_NREG,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int CW    = 16,
    localparam int RW    = tag_w(NREG),
    localparam int SW    = sel_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_rs1_used,
    input  logic          id_rs2_used,
    input  logic [RW-1:0] id_ws,
    input  logic          id_wr,
    input  logic          id_ld,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwd_sel1,
    output logic [SW-1:0] fwd_sel2,
    output logic [NREG-1:0] busy_vec,
    output logic [CW-1:0] stall_count
);

    localparam int CNTW = SW;

    tag_entry_t [DEPTH-1:0] stage;
    tag_entry_t             issue_entry;
    tag_entry_t             retire;
    logic [CNTW-1:0]        cnt [NREG];
    logic [NREG-1:0]        inc_vec;
    logic [NREG-1:0]        dec_vec;
    logic                   issue;
    logic                   ld_in;

    logic [DEPTH-1:0]       unused_match1;
    logic [DEPTH-1:0]       unused_match2;
    logic [SW-1:0]          sel1;
    logic [SW-1:0]          sel2;
    logic                   any1;
    logic                   any2;
    logic                   lu1;
    logic                   lu2;
    logic                   unused_fwd;

    sb_match #(.NREG(NREG), .DEPTH(DEPTH)) u_match_rs1 (
        .valid    (id_valid),
        .used     (id_rs1_used),
        .src      (id_rs1),
        .entries  (stage),
        .match    (unused_match1),
        .sel      (sel1),
        .any      (any1),
        .load_use (lu1)
    );

    sb_match #(.NREG(NREG), .DEPTH(DEPTH)) u_match_rs2 (
        .valid    (id_valid),
        .used     (id_rs2_used),
        .src      (id_rs2),
        .entries  (stage),
        .match    (unused_match2),
        .sel      (sel2),
        .any      (any2),
        .load_use (lu2)
    );

`ifdef HAZARD_SB_FWD_EN
    assign stall      = lu1 | lu2;
    assign fwd_sel1   = sel1;
    assign fwd_sel2   = sel2;
    assign ld_in      = id_ld;
    assign unused_fwd = ^{any1, any2};
`else
    // Stage DEPTH-1 is included: the RF does not bypass a same-cycle WB write.
    assign stall      = any1 | any2;
    assign fwd_sel1   = '0;
    assign fwd_sel2   = '0;
    assign ld_in      = 1'b0;
    assign unused_fwd = ^{sel1, sel2, lu1, lu2, id_ld};
`endif

    // flush kills the decode instruction even when it is also stalled.
    assign issue  = id_valid & ~stall & ~flush;
    assign retire = stage[DEPTH-1];

    always_comb begin
        issue_entry    = '0;
        issue_entry.v  = 1'b1;
        issue_entry.wr = id_wr;
        issue_entry.ld = ld_in;
        issue_entry.ws = TAG_MAX'(id_ws);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= issue ? issue_entry : '0;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            inc_vec[r] = issue & id_wr & (id_ws == RW'(r));
            dec_vec[r] = retire.v & retire.wr & (retire.ws == TAG_MAX'(r));
        end
    end

    // Simultaneous issue and retire to one register cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r] && (cnt[r] != CNTW'(DEPTH))) begin
                    cnt[r] <= cnt[r] + CNTW'(1);
                end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNTW'(1);
                end
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && !flush && (stall_count != '1)) begin
            stall_count <= stall_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    localparam int NREG  = 8;
    localparam int DEPTH = 3;
    localparam int CW    = 6;
    localparam int RW    = $clog2(NREG);
    localparam int SW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [RW-1:0]   id_rs1 = '0;
    logic [RW-1:0]   id_rs2 = '0;
    logic            id_rs1_used = 1'b0;
    logic            id_rs2_used = 1'b0;
    logic [RW-1:0]   id_ws = '0;
    logic            id_wr = 1'b0;
    logic            id_ld = 1'b0;
    logic            flush = 1'b0;
    logic            stall;
    logic [SW-1:0]   fwd_sel1;
    logic [SW-1:0]   fwd_sel2;
    logic [NREG-1:0] busy_vec;
    logic [CW-1:0]   stall_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_ws       (id_ws),
        .id_wr       (id_wr),
        .id_ld       (id_ld),
        .flush       (flush),
        .stall       (stall),
        .fwd_sel1    (fwd_sel1),
        .fwd_sel2    (fwd_sel2),
        .busy_vec    (busy_vec),
        .stall_count (stall_count)
    );

    int checks = 0;
    int errors = 0;

    // Model: list of issued writes stamped with the cycle they left decode.
    typedef struct {
        int c;
        int ws;
        bit wr;
        bit ld;
    } rec_t;

    rec_t            q[$];
    int              now = 0;
    int              sc  = 0;
    bit              e_stall;
    int              e_sel1;
    int              e_sel2;
    logic [NREG-1:0] e_busy;
    logic            obs_stall;
    logic [SW-1:0]   obs_sel1;
    logic [SW-1:0]   obs_sel2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_eval();
        int b1 = -1;
        int b2 = -1;
        bit l1 = 1'b0;
        bit l2 = 1'b0;
        e_busy = '0;
        foreach (q[k]) begin
            int st;
            st = now - q[k].c - 1;
            if (q[k].wr) begin
                e_busy[q[k].ws] = 1'b1;
                if (id_valid && id_rs1_used && q[k].ws == int'(id_rs1) && (b1 < 0 || st < b1)) begin
                    b1 = st;
                    l1 = q[k].ld;
                end
                if (id_valid && id_rs2_used && q[k].ws == int'(id_rs2) && (b2 < 0 || st < b2)) begin
                    b2 = st;
                    l2 = q[k].ld;
                end
            end
        end
`ifdef HAZARD_SB_FWD_EN
        e_stall = (b1 == 0 && l1) || (b2 == 0 && l2);
        e_sel1  = b1 + 1;
        e_sel2  = b2 + 1;
`else
        e_stall = (b1 >= 0) || (b2 >= 0);
        e_sel1  = 0;
        e_sel2  = 0;
`endif
    endfunction

    // Called at posedge+1: checks outputs mid-cycle, then advances the model.
    task automatic cycle();
        bit iss;
        #3;
        model_eval();
        obs_stall = stall;
        obs_sel1  = fwd_sel1;
        obs_sel2  = fwd_sel2;
        chk("stall", stall, e_stall);
        chk("fwd_sel1", fwd_sel1, e_sel1);
        chk("fwd_sel2", fwd_sel2, e_sel2);
        chk("busy_vec", busy_vec, e_busy);
        chk("stall_count", stall_count, sc);
        iss = id_valid && !e_stall && !flush;
        @(posedge clk);
        if (iss) begin
`ifdef HAZARD_SB_FWD_EN
            q.push_back('{now, int'(id_ws), id_wr, id_ld});
`else
            q.push_back('{now, int'(id_ws), id_wr, 1'b0});
`endif
        end
        if (e_stall && !flush && sc < (1 << CW) - 1) sc++;
        now++;
        while (q.size() > 0 && now - q[0].c - 1 >= DEPTH) void'(q.pop_front());
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_fwd_sel1", fwd_sel1, 0);
        chk("rst_fwd_sel2", fwd_sel2, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_stall_count", stall_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        sc = 0;
        now++;
        chk("rst_busy_after", busy_vec, 0);
    endtask

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int ws, input bit wr, input bit ld, input bit fl);
        id_valid    = v;
        id_rs1      = RW'(rs1);
        id_rs1_used = u1;
        id_rs2      = RW'(rs2);
        id_rs2_used = u2;
        id_ws       = RW'(ws);
        id_wr       = wr;
        id_ld       = ld;
        flush       = fl;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int n;
        #1;
        do_reset();

        // Back-to-back RAW on r3.
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0);
        cycle();
        set_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (!obs_stall) break;
            n++;
        end
`ifdef HAZARD_SB_FWD_EN
        chk("raw_stall_cycles", n, 0);
        chk("raw_fwd_sel1", obs_sel1, 1);
        chk("raw_stall_count", stall_count, 0);
`else
        chk("raw_stall_cycles", n, 3);
        chk("raw_stall_count", stall_count, 3);
`endif
        idle(DEPTH + 1);
        chk("raw_drained", busy_vec, 0);

`ifdef HAZARD_SB_FWD_EN
        // ALU producer, then successive independent reads of r3.
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0);
        cycle();
        set_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("alu_sel_ex", obs_sel1, 1);
        cycle();
        chk("alu_sel_mem", obs_sel1, 2);
        cycle();
        chk("alu_sel_wb", obs_sel1, 3);
        cycle();
        chk("alu_sel_retired", obs_sel1, 0);
        idle(DEPTH);

        // Load r2 then immediate use as rs2.
        set_id(1, 0, 0, 0, 0, 2, 1, 1, 0);
        cycle();
        set_id(1, 0, 0, 2, 1, 0, 0, 0, 0);
        cycle();
        chk("lu_stall", obs_stall, 1);
        cycle();
        chk("lu_released", obs_stall, 0);
        chk("lu_sel2", obs_sel2, 2);
        idle(DEPTH + 1);
`endif

        // Flush while the decode instruction matches stage 0.
        do_reset();
        set_id(1, 0, 0, 0, 0, 4, 1, 1, 0);
        cycle();
        set_id(1, 4, 1, 0, 0, 6, 1, 0, 1);
        cycle();
        chk("flush_stall_reported", obs_stall, 1);
        chk("flush_count_held", stall_count, 0);
        idle(1);
        chk("flush_not_recorded", busy_vec[6], 0);
        chk("flush_producer_busy", busy_vec[4], 1);
        idle(DEPTH);
        chk("flush_drained", busy_vec, 0);

        // Same-register issue/retire collision on r5, then fill to DEPTH.
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
        cycle();
        idle(2);
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
        cycle();
        chk("coll_busy5", busy_vec[5], 1);
        chk("coll_cnt5", dut.cnt[5], 1);
        cycle();
        cycle();
        chk("fill_cnt5", dut.cnt[5], DEPTH);
        cycle();
        chk("fill_cnt5_held", dut.cnt[5], DEPTH);
        idle(DEPTH);
        chk("fill_cnt5_drained", dut.cnt[5], 0);
        chk("fill_busy_drained", busy_vec, 0);

        // Randomized traffic, with occasional mid-operation resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            set_id($urandom_range(0, 3) != 0,
                   $urandom_range(0, NREG - 1), $urandom_range(0, 1),
                   $urandom_range(0, NREG - 1), $urandom_range(0, 1),
                   $urandom_range(0, NREG - 1), $urandom_range(0, 2) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            cycle();
        end
        idle(DEPTH + 1);
        chk("final_drained", busy_vec, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised RAW-hazard tracker for the in-order pipeline. It sits beside the decode stage and tracks each in-flight register write in a DEPTH-entry tag pipeline that mirrors the stages after decode (EX, MEM, WB for DEPTH=3). It asserts `stall` when a decode-stage source matches a pending write, and inserts bubbles on stall or branch flush. With forwarding compiled in, it selects bypass sources and stalls only on load-use.

## Interface
- `NREG`, default 8: number of architectural registers. Tag width is `RW = $clog2(NREG)`.
- `DEPTH`, default 3: stages from EX through WB, inclusive. Must be ≥ 1.
- `CW`, default 16: width of the stall performance counter.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `id_valid`, input, 1: the decode stage holds a real instruction.
- `id_rs1`, `id_rs2`, input, RW each: source register tags.
- `id_rs1_used`, `id_rs2_used`, input, 1 each: the instruction actually reads that source.
- `id_ws`, input, RW: destination tag.
- `id_wr`, input, 1: the instruction writes `id_ws`.
- `id_ld`, input, 1: the instruction is a load, so its result is available only after MEM.
- `flush`, input, 1: branch taken in EX; the decode-stage instruction is killed this cycle.
- `stall`, output, 1: hold IF/ID, insert a bubble into EX.
- `fwd_sel1`, `fwd_sel2`, output, `$clog2(DEPTH+1)` each: 0 = register file; k = result from stage k-1.
- `busy_vec`, output, NREG: bit r set when any in-flight stage will write register r.
- `stall_count`, output, CW: saturating count of stall cycles.

## Operation
- Stage i (0..DEPTH-1) holds `{v, wr, ld, ws}`. Stage 0 is EX.
- Match rule: source s matches stage i when `id_valid & s_used & v[i] & wr[i] & (ws[i] == s)`.
- Issue: when `id_valid & !stall & !flush`, stage 0 loads `{1, id_wr, id_ld, id_ws}` at the next edge. Otherwise stage 0 loads a bubble (`v = 0`).
- Shift: stage i+1 loads stage i every cycle. Stage DEPTH-1 retires; its write lands in the RF that edge.
- Retire/read rule: WB write and ID read in the same cycle are not bypassed by the RF. A match in stage DEPTH-1 is therefore a hazard.
- `flush` has priority over `stall`. A flushed instruction is never recorded. `stall` is still reported (combinational) during flush; the caller ORs the two.
- `flush` does not alter stages 0..DEPTH-1. The branch itself proceeds.
- Pending counters: one per register, width `$clog2(DEPTH+1)`. Increment on issue with `id_wr`; decrement on retire of `v & wr`. Both in the same cycle to the same register leaves the count unchanged.
- `busy_vec[r] = (cnt[r] != 0)`. A counter must never exceed DEPTH or go below 0.
- `stall_count` increments when `stall & !flush` and saturates at all-ones.

## Timing
- `stall`, `fwd_sel1`, `fwd_sel2`: combinational, same cycle as the ID inputs.
- Stage, counter and perf state: registered, 1-cycle update.
- Reset values, applied immediately:
  - all stage `v = 0`, all counters 0
  - `busy_vec = 0`, `stall_count = 0`
  - `stall = 0`, `fwd_sel* = 0`
- Reset mid-operation discards all in-flight tags. There is no replay.
- Stall duration without forwarding: a producer issued at cycle t blocks a dependent until cycle t+DEPTH; the dependent issues at edge t+DEPTH.
- Multiple matches: the youngest stage (lowest i) wins for forwarding selection.

## Configuration
- Macro `HAZARD_SB_FWD_EN`.
- Defined:
  - `stall` = any source matches stage 0 with `ld[0] = 1` (load-use).
  - `fwd_selN` = 1 + index of the youngest matching stage, else 0.
  - A load in stage 1 or later forwards normally.
- Undefined:
  - `stall` = any source matches any stage.
  - `fwd_sel1` and `fwd_sel2` tied to 0.
  - The `id_ld` input is ignored.

## Structure
- Shared package `pipe_pkg`:
  - NOP encoding `16'h0800`
  - `tag_entry_t` struct `{v, wr, ld, ws}`
  - default NREG/DEPTH constants
  - `$clog2` width helpers
- One sub-module, `sb_match`: a combinational comparator of one source tag against all DEPTH entries. It returns a match vector plus youngest-match index and load-use flag. It is instantiated twice (rs1, rs2).

## Test plan
- **Reset:** assert `rst` with stage contents nonzero → all outputs 0 at once; `busy_vec = 0` after release.
- **Back-to-back RAW, forwarding off:** issue wr r3, then a reader of r3 as rs1 → `stall` high for exactly 3 cycles; reader issues on the 4th; `stall_count = 3`.
- **Forwarding on, ALU producer then consumer:** `stall = 0`; `fwd_sel1 = 1`, then 2 and 3 on successive independent reads of r3; 0 after retire.
- **Forwarding on, load r2 then immediate use:** 1 stall cycle, then `fwd_sel = 2`.
- **Flush during stall:** hold `flush = 1` while ID matches stage 0 → stage 0 gets a bubble, `stall_count` is unchanged, and no entry is recorded for the killed instruction.
- **Same-register issue/retire collision:** r5 written by the retiring entry and by a new issue in the same cycle → `cnt[5]` is unchanged and `busy_vec[5]` stays 1; fill DEPTH writes to r5 → `cnt[5] = DEPTH`, no overflow.
